// File: rtl/settle_pkg.sv
// settle_pkg: shared types and default sizes for the settling-time monitor
package settle_pkg;
  typedef enum logic [1:0] {IDLE, OUT_BAND, IN_BAND} state_t;
  localparam int DEF_WIDTH = 18;
  localparam int DEF_CNT_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_MOST_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};
endpackage

// File: rtl/settle_detector_band_compare.sv
// band_compare: flags a sample lying within tol of target, using one extra bit so extreme operands cannot wrap
module band_compare #(
  parameter int WIDTH = 18
) (
  input  logic signed [WIDTH-1:0] v_in,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-1:0] tol,
  output logic                    in_band
);
  logic signed [WIDTH:0] err;
  logic        [WIDTH:0] mag;
  // widened difference, magnitude and inclusive band compare
  always_comb begin
    err = {v_in[WIDTH-1], v_in} - {target[WIDTH-1], target};
    mag = err[WIDTH] ? -err : err;
    in_band = mag <= {1'b0, tol};
  end
endmodule

// File: rtl/settle_detector.sv
// settle_detector: measures settling time, peak and timeout of a sample stream after a start pulse
module settle_detector
  import settle_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXPONENT = -12,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [WIDTH-1:0]     v_in,
  input  logic signed [WIDTH-1:0]     target,
  input  logic        [WIDTH-1:0]     tol,
  output logic                        busy,
  output logic                        done,
  output logic                        settled,
  output logic        [CNT_WIDTH-1:0] settle_time,
  output logic signed [WIDTH-1:0]     peak
);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  if (HOLD_CYCLES < 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 2**CNT_WIDTH - 1 || EXPONENT < -65536) begin : g_bad_params
    $error("settle_detector: parameter out of legal range");
  end
  state_t state;
  logic in_band, settle_now, timeout_now;
  logic [CNT_WIDTH-1:0] elapsed, hold, entry;
  band_compare #(.WIDTH(WIDTH)) u_band (
    .v_in(v_in),
    .target(target),
    .tol(tol),
    .in_band(in_band)
  );
  assign settle_now = state == IN_BAND && in_band && hold + 1'b1 == CNT_WIDTH'(HOLD_CYCLES);
  assign timeout_now = elapsed == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  // measurement FSM with peak tracking; settling beats timeout on the same sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      settled <= 1'b0;
      settle_time <= '0;
      peak <= '0;
      elapsed <= '0;
      hold <= '0;
      entry <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= OUT_BAND;
          busy <= 1'b1;
          elapsed <= '0;
          hold <= '0;
          peak <= MOST_NEG;
          settled <= 1'b0;
        end
      end else begin
        peak <= v_in > peak ? v_in : peak;
        elapsed <= elapsed + 1'b1;
        if (settle_now || timeout_now) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          settled <= settle_now;
          settle_time <= settle_now ? entry : '1;
        end else if (state == OUT_BAND) begin
          if (in_band) begin
            entry <= elapsed;
            hold <= CNT_WIDTH'(1);
            state <= IN_BAND;
          end
        end else begin
          hold <= in_band ? hold + 1'b1 : '0;
          state <= in_band ? IN_BAND : OUT_BAND;
        end
      end
    end
  end
endmodule

// File: tb/tb_settle_detector.sv
// tb_settle_detector: directed checks of settling time, peak, timeout, band edges, reset and start handling
module tb_settle_detector;
  localparam int W = 18;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst, start;
  logic signed [W-1:0] v_in, target;
  logic [W-1:0] tol;
  logic busy, done, settled;
  logic [CW-1:0] settle_time;
  logic signed [W-1:0] peak;
  int checks = 0;
  int errors = 0;

  settle_detector #(
    .WIDTH(W), .EXPONENT(-12), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(64), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .v_in(v_in), .target(target), .tol(tol),
    .busy(busy), .done(done), .settled(settled), .settle_time(settle_time), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stim(input int pat, input int i);
    case (pat)
      0: return 4096;
      1: return i < 10 ? 0 : 4096;
      2: return i < 5 ? 0 : i < 12 ? 4096 : i < 20 ? 4300 : 4096;
      4: return -4137;
      5: return -4138;
      6: return -131072;
      default: return 0;
    endcase
  endfunction

  task automatic measure(input int pat, input bit do_start, input int poke, output int idx);
    idx = -1;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      v_in = W'(stim(pat, i));
      start = (i == poke);
      tick();
      start = 1'b0;
      if (done) begin
        idx = i;
        break;
      end
    end
  endtask

  task automatic expect_result(input string tag, input int idx, input int idx_exp,
                               input int s_exp, input int st_exp, input int pk_exp);
    chk({tag, "_done_idx"}, idx, idx_exp);
    chk({tag, "_settled"}, int'(settled), s_exp);
    chk({tag, "_settle_time"}, int'(settle_time), st_exp);
    chk({tag, "_peak"}, int'(peak), pk_exp);
  endtask

  initial begin
    int idx, pulses;
    rst = 1'b1;
    start = 1'b0;
    v_in = '0;
    target = '0;
    tol = '0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_settled", int'(settled), 0);
    chk("rst_settle_time", int'(settle_time), 0);
    chk("rst_peak", int'(peak), 0);
    rst = 1'b0;
    tick();
    target = 4096;
    tol = 41;
    measure(0, 1'b1, -1, idx);
    expect_result("hold", idx, 15, 1, 0, 4096);
    chk("hold_busy_at_done", int'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cycle_start_busy", int'(busy), 1);
    chk("done_one_cycle", int'(done), 0);
    chk("restart_settled_clear", int'(settled), 0);
    measure(0, 1'b0, -1, idx);
    expect_result("restart", idx, 15, 1, 0, 4096);
    measure(1, 1'b1, -1, idx);
    expect_result("step", idx, 25, 1, 10, 4096);
    measure(1, 1'b1, 12, idx);
    expect_result("busy_start", idx, 25, 1, 10, 4096);
    measure(2, 1'b1, -1, idx);
    expect_result("ring", idx, 35, 1, 20, 4300);
    measure(3, 1'b1, -1, idx);
    expect_result("timeout", idx, 63, 0, 65535, 0);
    target = -4096;
    measure(4, 1'b1, -1, idx);
    expect_result("edge_in", idx, 15, 1, 0, -4137);
    measure(5, 1'b1, -1, idx);
    expect_result("edge_out", idx, 63, 0, 65535, -4138);
    target = 131071;
    measure(6, 1'b1, -1, idx);
    expect_result("extreme", idx, 63, 0, 65535, -131072);
    target = 4096;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v_in = W'(stim(0, i));
      tick();
    end
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_settled", int'(settled), 0);
    chk("mid_rst_settle_time", int'(settle_time), 0);
    chk("mid_rst_peak", int'(peak), 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      pulses += int'(done) + int'(busy);
    end
    chk("mid_rst_no_done", pulses, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
